// File: rtl/assoc_cache.sv
// assoc_cache: 2-way set-associative, write-back, write-allocate cache with per-set
// LRU replacement, a req/ack line-wide memory port and a dirty-line flush engine.
module assoc_cache #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int OFFSET_W = 4,
    parameter int INDEX_W  = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cpu_req,
    input  logic                            cpu_we,
    input  logic [ADDR_W-1:0]               cpu_addr,
    input  logic [DATA_W-1:0]               cpu_wdata,
    output logic [DATA_W-1:0]               cpu_rdata,
    output logic                            cpu_ready,
    input  logic                            flush,
    output logic                            flush_busy,
    output logic                            flush_done,
    output logic                            mem_req,
    output logic                            mem_we,
    output logic [ADDR_W-OFFSET_W-1:0]      mem_addr,
    output logic [(DATA_W<<OFFSET_W)-1:0]   mem_wdata,
    input  logic [(DATA_W<<OFFSET_W)-1:0]   mem_rdata,
    input  logic                            mem_ack
);
    localparam int LINE_W  = DATA_W << OFFSET_W;
    localparam int SETS    = 1 << INDEX_W;
    localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LADDR_W = ADDR_W - OFFSET_W;
    localparam int SLOT_W  = INDEX_W + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB      = 3'd1,
        FILL    = 3'd2,
        FL_SCAN = 3'd3,
        FL_WB   = 3'd4,
        FL_DONE = 3'd5
    } state_e;

    logic [TAG_W-1:0]   tag_r   [2][SETS];
    logic [LINE_W-1:0]  data_r  [2][SETS];
    logic [SETS-1:0]    valid_r [2];
    logic [SETS-1:0]    dirty_r [2];
    logic [SETS-1:0]    lru_r;

    state_e             state_r;
    state_e             state_s;
    logic               victim_r;
    logic [LADDR_W-1:0] line_r;
    logic [SLOT_W-1:0]  slot_r;

    logic [TAG_W-1:0]    req_tag_s;
    logic [INDEX_W-1:0]  req_idx_s;
    logic [OFFSET_W-1:0] req_off_s;
    logic                hit0_s;
    logic                hit1_s;
    logic                hit_s;
    logic                hit_way_s;
    logic                victim_s;
    logic                victim_dirty_s;
    logic                hit_acc_s;
    logic                miss_s;
    logic                flush_go_s;
    logic                fill_done_s;
    logic                flwb_done_s;
    logic [INDEX_W-1:0]  line_idx_s;
    logic [TAG_W-1:0]    line_tag_s;
    logic [INDEX_W-1:0]  fl_set_s;
    logic                fl_way_s;
    logic                slot_last_s;
    logic                slot_dirty_s;
    logic [LINE_W-1:0]   rd_line_s;
    logic [LINE_W-1:0]   wr_line_s;

    assign req_tag_s   = cpu_addr[ADDR_W-1 -: TAG_W];
    assign req_idx_s   = cpu_addr[OFFSET_W +: INDEX_W];
    assign req_off_s   = cpu_addr[OFFSET_W-1:0];
    assign hit0_s      = valid_r[0][req_idx_s] && (tag_r[0][req_idx_s] == req_tag_s);
    assign hit1_s      = valid_r[1][req_idx_s] && (tag_r[1][req_idx_s] == req_tag_s);
    assign hit_s       = hit0_s || hit1_s;
    assign hit_way_s   = !hit0_s;

    assign flush_go_s  = (state_r == IDLE) && flush;
    assign hit_acc_s   = (state_r == IDLE) && !flush && cpu_req && hit_s;
    assign miss_s      = (state_r == IDLE) && !flush && cpu_req && !hit_s;
    assign fill_done_s = (state_r == FILL) && mem_ack;
    assign flwb_done_s = (state_r == FL_WB) && mem_ack;

    // Miss handling works from the captured line address, not the live CPU bus
    assign line_idx_s  = line_r[INDEX_W-1:0];
    assign line_tag_s  = line_r[LADDR_W-1 -: TAG_W];

    assign fl_set_s     = slot_r[SLOT_W-1:1];
    assign fl_way_s     = slot_r[0];
    assign slot_last_s  = (slot_r == {SLOT_W{1'b1}});
    assign slot_dirty_s = valid_r[fl_way_s][fl_set_s] && dirty_r[fl_way_s][fl_set_s];

    // Victim selection: first invalid way, else the LRU way
    always_comb begin
        victim_s = lru_r[req_idx_s];
        if (!valid_r[0][req_idx_s]) begin
            victim_s = 1'b0;
        end else if (!valid_r[1][req_idx_s]) begin
            victim_s = 1'b1;
        end else begin
            victim_s = lru_r[req_idx_s];
        end
        victim_dirty_s = valid_r[victim_s][req_idx_s] && dirty_r[victim_s][req_idx_s];
    end

    // Hit-way read word and the line merged with the write word
    always_comb begin
        rd_line_s = data_r[0][req_idx_s];
        if (hit1_s) begin
            rd_line_s = data_r[1][req_idx_s];
        end else begin
            rd_line_s = data_r[0][req_idx_s];
        end
        cpu_rdata = rd_line_s[req_off_s*DATA_W +: DATA_W];
        wr_line_s = rd_line_s;
        wr_line_s[req_off_s*DATA_W +: DATA_W] = cpu_wdata;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (flush) begin
                    state_s = FL_SCAN;
                end else if (cpu_req && !hit_s) begin
                    state_s = victim_dirty_s ? WB : FILL;
                end else begin
                    state_s = IDLE;
                end
            end
            WB: begin
                state_s = mem_ack ? FILL : WB;
            end
            FILL: begin
                state_s = mem_ack ? IDLE : FILL;
            end
            FL_SCAN: begin
                if (slot_dirty_s) begin
                    state_s = FL_WB;
                end else if (slot_last_s) begin
                    state_s = FL_DONE;
                end else begin
                    state_s = FL_SCAN;
                end
            end
            FL_WB: begin
                if (!mem_ack) begin
                    state_s = FL_WB;
                end else if (slot_last_s) begin
                    state_s = FL_DONE;
                end else begin
                    state_s = FL_SCAN;
                end
            end
            FL_DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output decode from registered state, victim way and scan slot
    always_comb begin
        cpu_ready  = 1'b0;
        flush_busy = 1'b0;
        flush_done = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = line_r;
        mem_wdata  = data_r[victim_r][line_idx_s];
        case (state_r)
            IDLE: begin
                cpu_ready = !cpu_req || (hit_s && !flush);
            end
            WB: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {tag_r[victim_r][line_idx_s], line_idx_s};
            end
            FILL: begin
                mem_req = 1'b1;
            end
            FL_SCAN: begin
                flush_busy = 1'b1;
            end
            FL_WB: begin
                flush_busy = 1'b1;
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = {tag_r[fl_way_s][fl_set_s], fl_set_s};
                mem_wdata  = data_r[fl_way_s][fl_set_s];
            end
            FL_DONE: begin
                flush_busy = 1'b1;
                flush_done = 1'b1;
            end
            default: begin
                cpu_ready = 1'b0;
            end
        endcase
    end

    // Miss bookkeeping and flush scan pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            victim_r <= 1'b0;
            line_r   <= {LADDR_W{1'b0}};
            slot_r   <= {SLOT_W{1'b0}};
        end else begin
            if (miss_s) begin
                victim_r <= victim_s;
                line_r   <= cpu_addr[ADDR_W-1:OFFSET_W];
            end
            if (flush_go_s) begin
                slot_r <= {SLOT_W{1'b0}};
            end else if (((state_r == FL_SCAN) && !slot_dirty_s) || flwb_done_s) begin
                slot_r <= slot_r + {{(SLOT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Valid, dirty and LRU status bits
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r[0] <= {SETS{1'b0}};
            valid_r[1] <= {SETS{1'b0}};
            dirty_r[0] <= {SETS{1'b0}};
            dirty_r[1] <= {SETS{1'b0}};
            lru_r      <= {SETS{1'b0}};
        end else if (fill_done_s) begin
            valid_r[victim_r][line_idx_s] <= 1'b1;
            dirty_r[victim_r][line_idx_s] <= 1'b0;
            lru_r[line_idx_s]             <= !victim_r;
        end else if (hit_acc_s) begin
            if (cpu_we) begin
                dirty_r[hit_way_s][req_idx_s] <= 1'b1;
            end
            lru_r[req_idx_s] <= !hit_way_s;
        end else if (flwb_done_s) begin
            dirty_r[fl_way_s][fl_set_s] <= 1'b0;
        end
    end

    // Tag and data arrays; reset only blocks writes, contents are not cleared
    always_ff @(posedge clk) begin
        if (!rst && fill_done_s) begin
            data_r[victim_r][line_idx_s] <= mem_rdata;
            tag_r[victim_r][line_idx_s]  <= line_tag_s;
        end else if (!rst && hit_acc_s && cpu_we) begin
            data_r[hit_way_s][req_idx_s] <= wr_line_s;
        end
    end

endmodule

// File: tb/tb_assoc_cache.sv
// Directed self-checking bench for assoc_cache with a scripted line memory responder.
module tb_assoc_cache;
    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req;
    logic         cpu_we;
    logic [15:0]  cpu_addr;
    logic [15:0]  cpu_wdata;
    logic [15:0]  cpu_rdata;
    logic         cpu_ready;
    logic         flush;
    logic         flush_busy;
    logic         flush_done;
    logic         mem_req;
    logic         mem_we;
    logic [11:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_ack;

    int tests_run = 0;
    int fail_cnt  = 0;

    logic         stable_ok;
    int           log_n;
    logic         log_we    [16];
    logic [11:0]  log_addr  [16];
    logic [255:0] log_wdata [16];

    assoc_cache dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .flush(flush), .flush_busy(flush_busy), .flush_done(flush_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // Memory contents: line 0x004 holds 0x1000+k, other lines are offset by 0x10 per line
    function automatic logic [255:0] fill_line(input logic [11:0] la);
        logic [255:0] l;
        logic [11:0]  b;
        b = la - 12'h004;
        for (int k = 0; k < 16; k++) l[k*16 +: 16] = 16'h1000 + {b, 4'(k)};
        return l;
    endfunction

    task automatic log_txn();
        if (log_n < 16) begin
            log_we[log_n]    = mem_we;
            log_addr[log_n]  = mem_addr;
            log_wdata[log_n] = mem_wdata;
        end
        log_n++;
    endtask

    // One CPU access; memory acks after ack_delay wait cycles; cycles=-1 on timeout
    task automatic do_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                             input int ack_delay, output int cycles, output logic [15:0] rdata);
        int          wait_n;
        logic        active;
        logic [11:0] req_addr;
        logic        req_we;
        cycles = -1; rdata = 16'h0000; wait_n = 0; active = 1'b0;
        req_addr = 12'h000; req_we = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
            #1;
            if (cpu_ready) begin
                cycles = c;
                rdata  = cpu_rdata;
                break;
            end
            if (mem_req) begin
                if (!active) begin
                    active = 1'b1; req_addr = mem_addr; req_we = mem_we; wait_n = 0;
                end else if (mem_addr !== req_addr || mem_we !== req_we) begin
                    stable_ok = 1'b0;
                end
                if (wait_n == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = fill_line(mem_addr);
                    log_txn();
                    active = 1'b0;
                end else begin
                    wait_n++;
                end
            end
        end
        @(negedge clk);
        cpu_req = 1'b0;
        mem_ack = 1'b0;
    endtask

    // Flush pulse; acks write-backs immediately; reports flush_done cycle and busy after it
    task automatic do_flush(output int done_cycle, output logic busy_after);
        done_cycle = -1; busy_after = 1'bx;
        @(negedge clk);
        cpu_req = 1'b0; flush = 1'b1; mem_ack = 1'b0;
        for (int c = 1; c < 100; c++) begin
            @(negedge clk);
            flush = 1'b0; mem_ack = 1'b0;
            #1;
            if (flush_done) begin
                done_cycle = c;
                @(negedge clk);
                #1;
                busy_after = flush_busy;
                break;
            end
            if (mem_req) begin
                mem_ack = 1'b1;
                log_txn();
            end
        end
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
        flush = 1'b0; mem_ack = 1'b0; mem_rdata = 256'd0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        tests_run++; if (mem_req !== 1'b0) begin fail_cnt++; $display("FAIL reset_mem_req: got %0b want 0", mem_req); end
        tests_run++; if (mem_we !== 1'b0) begin fail_cnt++; $display("FAIL reset_mem_we: got %0b want 0", mem_we); end
        tests_run++; if (flush_busy !== 1'b0 || flush_done !== 1'b0) begin fail_cnt++; $display("FAIL reset_flush: got busy=%0b done=%0b want 0 0", flush_busy, flush_done); end
        tests_run++; if (cpu_ready !== 1'b1) begin fail_cnt++; $display("FAIL reset_ready_idle: got %0b want 1", cpu_ready); end
        cpu_req = 1'b1; cpu_addr = 16'h0043; #1;
        tests_run++; if (cpu_ready !== 1'b0) begin fail_cnt++; $display("FAIL reset_ready_req: got %0b want 0", cpu_ready); end
        @(negedge clk);
        cpu_req = 1'b0; rst = 1'b0;
    endtask

    task automatic test_cold_read();
        int cyc; logic [15:0] rd;
        log_n = 0;
        do_access(1'b0, 16'h0043, 16'h0000, 0, cyc, rd);
        tests_run++; if (cyc !== 2) begin fail_cnt++; $display("FAIL cold_latency: got %0d want 2", cyc); end
        tests_run++; if (rd !== 16'h1003) begin fail_cnt++; $display("FAIL cold_rdata: got %h want 1003", rd); end
        tests_run++; if (log_n !== 1 || log_we[0] !== 1'b0 || log_addr[0] !== 12'h004) begin fail_cnt++; $display("FAIL cold_fill: got n=%0d we=%0b addr=%h want 1 0 004", log_n, log_we[0], log_addr[0]); end
        log_n = 0;
        do_access(1'b0, 16'h004F, 16'h0000, 0, cyc, rd);
        tests_run++; if (cyc !== 0 || rd !== 16'h100F) begin fail_cnt++; $display("FAIL hit_read: got cyc=%0d data=%h want 0 100f", cyc, rd); end
    endtask

    task automatic test_write_hit();
        int cyc; logic [15:0] rd;
        log_n = 0;
        do_access(1'b1, 16'h0045, 16'hBEEF, 0, cyc, rd);
        tests_run++; if (cyc !== 0) begin fail_cnt++; $display("FAIL write_hit_latency: got %0d want 0", cyc); end
        do_access(1'b0, 16'h0045, 16'h0000, 0, cyc, rd);
        tests_run++; if (cyc !== 0 || rd !== 16'hBEEF) begin fail_cnt++; $display("FAIL write_readback: got cyc=%0d data=%h want 0 beef", cyc, rd); end
        tests_run++; if (log_n !== 0) begin fail_cnt++; $display("FAIL write_hit_traffic: got %0d txns want 0", log_n); end
    endtask

    task automatic test_writeback();
        int cyc; logic [15:0] rd;
        log_n = 0;
        do_access(1'b0, 16'h0080, 16'h0000, 0, cyc, rd);
        tests_run++; if (cyc !== 2 || rd !== 16'h1040 || log_addr[0] !== 12'h008) begin fail_cnt++; $display("FAIL fill_way1: got cyc=%0d data=%h addr=%h want 2 1040 008", cyc, rd, log_addr[0]); end
        do_access(1'b0, 16'h0080, 16'h0000, 0, cyc, rd);
        tests_run++; if (cyc !== 0) begin fail_cnt++; $display("FAIL way1_hit: got %0d want 0", cyc); end
        log_n = 0;
        do_access(1'b0, 16'h00C0, 16'h0000, 0, cyc, rd);
        tests_run++; if (log_n !== 2 || log_we[0] !== 1'b1 || log_addr[0] !== 12'h004) begin fail_cnt++; $display("FAIL wb_addr: got n=%0d we=%0b addr=%h want 2 1 004", log_n, log_we[0], log_addr[0]); end
        tests_run++; if (log_wdata[0][5*16 +: 16] !== 16'hBEEF) begin fail_cnt++; $display("FAIL wb_word5: got %h want beef", log_wdata[0][5*16 +: 16]); end
        tests_run++; if (log_we[1] !== 1'b0 || log_addr[1] !== 12'h00C) begin fail_cnt++; $display("FAIL wb_then_fill: got we=%0b addr=%h want 0 00c", log_we[1], log_addr[1]); end
        tests_run++; if (cyc !== 3 || rd !== 16'h1080) begin fail_cnt++; $display("FAIL dirty_miss: got cyc=%0d data=%h want 3 1080", cyc, rd); end
        log_n = 0;
        do_access(1'b0, 16'h0080, 16'h0000, 0, cyc, rd);
        tests_run++; if (cyc !== 0 || rd !== 16'h1040 || log_n !== 0) begin fail_cnt++; $display("FAIL lru_keep: got cyc=%0d data=%h n=%0d want 0 1040 0", cyc, rd, log_n); end
    endtask

    task automatic test_flush();
        int cyc; int done_c; logic busy_a; logic [15:0] rd;
        do_access(1'b1, 16'h00C1, 16'hA5A5, 0, cyc, rd);
        tests_run++; if (cyc !== 0) begin fail_cnt++; $display("FAIL flush_setup_hit: got %0d want 0", cyc); end
        do_access(1'b1, 16'h0020, 16'h1234, 0, cyc, rd);
        tests_run++; if (cyc !== 2) begin fail_cnt++; $display("FAIL flush_setup_miss: got %0d want 2", cyc); end
        log_n = 0;
        do_flush(done_c, busy_a);
        tests_run++; if (log_n !== 2 || log_addr[0] !== 12'h00C || log_addr[1] !== 12'h002) begin fail_cnt++; $display("FAIL flush_order: got n=%0d %h %h want 2 00c 002", log_n, log_addr[0], log_addr[1]); end
        tests_run++; if (log_wdata[0][1*16 +: 16] !== 16'hA5A5 || log_wdata[1][15:0] !== 16'h1234) begin fail_cnt++; $display("FAIL flush_data: got %h %h want a5a5 1234", log_wdata[0][31:16], log_wdata[1][15:0]); end
        tests_run++; if (done_c !== 11 || busy_a !== 1'b0) begin fail_cnt++; $display("FAIL flush_done: got cycle=%0d busy=%0b want 11 0", done_c, busy_a); end
        log_n = 0;
        do_flush(done_c, busy_a);
        tests_run++; if (log_n !== 0) begin fail_cnt++; $display("FAIL flush_clean_wb: got %0d want 0", log_n); end
        tests_run++; if (done_c !== 9 || busy_a !== 1'b0) begin fail_cnt++; $display("FAIL flush_clean_done: got cycle=%0d busy=%0b want 9 0", done_c, busy_a); end
    endtask

    task automatic test_ack_delay();
        int cyc; logic [15:0] rd;
        log_n = 0; stable_ok = 1'b1;
        do_access(1'b0, 16'h0100, 16'h0000, 5, cyc, rd);
        tests_run++; if (cyc !== 7 || rd !== 16'h10C0) begin fail_cnt++; $display("FAIL delay_miss: got cyc=%0d data=%h want 7 10c0", cyc, rd); end
        tests_run++; if (stable_ok !== 1'b1 || log_n !== 1 || log_addr[0] !== 12'h010 || log_we[0] !== 1'b0) begin fail_cnt++; $display("FAIL delay_stable: got ok=%0b n=%0d addr=%h want 1 1 010", stable_ok, log_n, log_addr[0]); end
        @(negedge clk); mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0; #1;
        tests_run++; if (mem_req !== 1'b0 || cpu_ready !== 1'b1) begin fail_cnt++; $display("FAIL spurious_ack: got req=%0b ready=%0b want 0 1", mem_req, cpu_ready); end
        log_n = 0;
        do_access(1'b0, 16'h0100, 16'h0000, 0, cyc, rd);
        tests_run++; if (cyc !== 0 || rd !== 16'h10C0 || log_n !== 0) begin fail_cnt++; $display("FAIL spurious_hit: got cyc=%0d data=%h n=%0d want 0 10c0 0", cyc, rd, log_n); end
    endtask

    task automatic test_reset_in_fill();
        int cyc; logic [15:0] rd; logic seen;
        seen = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0043;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk); #1;
            if (mem_req) seen = 1'b1;
        end
        tests_run++; if (seen !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h004) begin fail_cnt++; $display("FAIL rst_fill_entry: got seen=%0b we=%0b addr=%h want 1 0 004", seen, mem_we, mem_addr); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; cpu_req = 1'b0; #1;
        tests_run++; if (mem_req !== 1'b0 || cpu_ready !== 1'b1 || flush_busy !== 1'b0) begin fail_cnt++; $display("FAIL rst_abort: got req=%0b ready=%0b busy=%0b want 0 1 0", mem_req, cpu_ready, flush_busy); end
        log_n = 0;
        do_access(1'b0, 16'h0043, 16'h0000, 0, cyc, rd);
        tests_run++; if (cyc !== 2 || rd !== 16'h1003 || log_n !== 1 || log_addr[0] !== 12'h004) begin fail_cnt++; $display("FAIL rst_refetch: got cyc=%0d data=%h n=%0d addr=%h want 2 1003 1 004", cyc, rd, log_n, log_addr[0]); end
    endtask

    initial begin
        stable_ok = 1'b1;
        log_n = 0;
        test_reset();
        test_cold_read();
        test_write_hit();
        test_writeback();
        test_flush();
        test_ack_delay();
        test_reset_in_fill();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule

// File: doc/assoc_cache.md
# assoc_cache

Parametrised 2-way set-associative, write-back, write-allocate cache between the CPU load/store port and the line-wide main memory. Replaces clock-gated stalling with an explicit `cpu_ready` stall and a req/ack memory handshake. Adds per-set LRU replacement and a software-triggered flush of all dirty lines.

## Interface
- `DATA_W`, default 16: CPU word width.
- `ADDR_W`, default 16: CPU word address width.
- `OFFSET_W`, default 4: log2 of words per line. `LINE_W = DATA_W << OFFSET_W`.
- `INDEX_W`, default 2: log2 of sets. `SETS = 1 << INDEX_W`. `TAG_W = ADDR_W - INDEX_W - OFFSET_W`.
- `clk` in 1: the single clock. All state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cpu_req` in 1: access request. `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in ADDR_W: word address; decoded as {tag, index, offset}.
- `cpu_wdata` in DATA_W: write data. `cpu_rdata` out DATA_W: read data.
- `cpu_ready` out 1: request completes this cycle.
- `flush` in 1: start flush (one-cycle pulse). `flush_busy` out 1. `flush_done` out 1: one-cycle pulse.
- `mem_req` out 1. `mem_we` out 1: 1 = write-back, 0 = fill.
- `mem_addr` out ADDR_W-OFFSET_W: line address {tag, index}.
- `mem_wdata` out LINE_W. `mem_rdata` in LINE_W. `mem_ack` in 1: one-cycle completion pulse.

## Operation
- Per set, per way: tag, valid, dirty, and a LINE_W data line. Line packing: word k occupies bits [k*DATA_W +: DATA_W] on `mem_rdata`, `mem_wdata` and in storage.
- Per-set LRU bit names the next victim way. On every hit or fill it is set to the other way.
- FSM states: IDLE, WB, FILL, FL_SCAN, FL_WB, FL_DONE.
- IDLE, with `cpu_req` high and a hit in either way:
  - `cpu_ready`=1 combinationally.
  - Read: `cpu_rdata` is the word, combinational.
  - Write: word written at the edge, dirty set.
- IDLE miss: `cpu_ready`=0. Victim is an invalid way if any (way 0 first), otherwise the LRU way.
  - Victim valid and dirty: go to WB.
  - Otherwise: go to FILL.
- WB: `mem_req`=1, `mem_we`=1, `mem_addr`={victim tag, index}, `mem_wdata`=victim line. On `mem_ack`, go to FILL.
- FILL: `mem_req`=1, `mem_we`=0, `mem_addr`={request tag, index}. On `mem_ack`, write line, tag, valid=1, dirty=0, update LRU, go to IDLE. The request then re-looks-up and hits; a write miss writes then (write-allocate).
- The CPU holds `cpu_req`, `cpu_we`, `cpu_addr`, `cpu_wdata` stable while `cpu_ready`=0.
- `cpu_ready`=1 in IDLE when `cpu_req`=0; 0 in every other state.
- Flush: `flush` is sampled only in IDLE. It has priority over `cpu_req` in the same cycle; that request stalls.
  - FL_SCAN visits slots (set 0 way 0, set 0 way 1, set 1 way 0, …), one slot per cycle.
  - A valid dirty slot goes to FL_WB: same signalling as WB. On `mem_ack` clear dirty (keep valid), then resume scan at the next slot.
  - After the last slot, go to FL_DONE: `flush_done`=1 for one cycle, then IDLE.
  - `flush_busy`=1 in FL_SCAN, FL_WB, FL_DONE.
- `mem_ack` is ignored when `mem_req`=0.

## Timing
- `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` decode from registered state and victim/way registers. They are stable for the whole request, including any number of wait cycles before `mem_ack`.
- Hit latency: 0 stall cycles.
- Clean miss: ready cycle = 1 + fill-ack delay + 1.
  - Miss detected cycle 0, FILL from cycle 1.
  - With `mem_ack` in the first FILL cycle, `cpu_ready`=1 in cycle 2.
- Dirty miss adds the WB handshake before FILL.
- Flush with no dirty lines: `flush_done` is high in cycle 2*SETS+1 after the accepting edge.
- Reset: every valid, dirty and LRU bit is 0; state IDLE. Data and tag arrays are not cleared.
  - Output reset values: `mem_req`=0, `mem_we`=0, `flush_busy`=0, `flush_done`=0, `cpu_ready`=!`cpu_req`.
- Reset mid-operation (WB, FILL, flush): abort. `mem_req`=0 in the cycle after the reset edge. No line is updated.

## Test plan
- Cold read `cpu_addr`=0x0043 after reset:
  - Required: `mem_req`=1, `mem_we`=0, `mem_addr`=0x004. Memory returns word k = 0x1000+k with ack 1 cycle later.
  - Required: `cpu_ready`=1 in cycle 2 with `cpu_rdata`=0x1003.
  - Then read 0x004F: 0 stall, data 0x100F.
- Write 0x0045 ← 0xBEEF (hit): 0 stall. Then read 0x0045 → 0xBEEF. No memory traffic.
- Reads 0x0080 (fills way 1, set 0), 0x0080 again, then 0x00C0:
  - Required: WB with `mem_addr`=0x004 and word 5 of `mem_wdata`=0xBEEF.
  - Then FILL with `mem_addr`=0x00C. Line 0x008 stays resident; read 0x0080 → hit.
- Dirty lines in set 0 and set 2, then `flush` pulse:
  - Required: exactly two writebacks in slot order, `flush_done` pulse, `flush_busy` low after it.
  - A second `flush` gives zero writebacks and `flush_done` in cycle 9 (SETS=4).
- Delay `mem_ack` by 5 cycles during a miss:
  - Required: `cpu_ready`=0 and `mem_addr`/`mem_we` constant throughout.
  - A spurious `mem_ack` while `mem_req`=0 has no effect.
- `rst` asserted in FILL:
  - Required: next cycle `mem_req`=0 and state IDLE.
  - Read of 0x0043 misses again and refetches `mem_addr`=0x004.
